// File: rtl/detector_frame_sequencer.sv
// ---------------------------------------------------------------------------
// detector_frame_sequencer
//
// Frame-synchronous controller for the colour-tracking datapath. It sits
// between the switch/host interface and the ball detector, and runs on the
// VGA pixel clock.
//
// The block has two jobs:
//   * It owns the Cr/Cb threshold registers used for red detection. Host
//     writes go into a shadow copy. The shadow is committed only at the end
//     of a frame, so that no frame is ever processed with two threshold sets.
//     At commit, each low/high pair is checked. A pair with low > high is
//     rejected and its shadow is reloaded from the active values.
//   * It sequences the detection RAM freeze line. A snapshot therefore always
//     holds one complete frame that used a single set of thresholds.
//
// Optional feature:
//   FRAME_COUNTER_EN - when defined, adds the oFrameCount output. This is a
//                      16-bit counter that counts frame ends and holds its
//                      value while FROZEN.
//
// Ports:
//   iVgaClk       in   VGA pixel clock. All logic is on the rising edge.
//   reset         in   Synchronous, active-high reset.
//   iVgaVRequest  in   High during the active vertical area of a frame.
//   iCfgValid     in   Host write request.
//   oCfgReady     out  A write is accepted when iCfgValid && oCfgReady.
//                      This output is low only in the frame-end cycle.
//   iCfgSel       in   Target field: 0 CrLow, 1 CrHigh, 2 CbLow, 3 CbHigh.
//   iCfgData      in   Write data.
//   iSnapReq      in   Single-cycle pulse that requests a snapshot.
//   iSnapRelease  in   Single-cycle pulse that returns to live video.
//   oCrLow/oCrHigh/oCbLow/oCbHigh  out  Active thresholds to the detector.
//   oFreezeRam    out  Drives the detector RAM freeze input.
//   oSnapState    out  0 LIVE, 1 ARM, 2 CAPTURE, 3 FROZEN.
//   oCfgPending   out  The shadow holds writes that are not yet committed.
//   oCfgErr       out  One-cycle pulse when a commit rejects a pair.
//   oFrameCount   out  (FRAME_COUNTER_EN only) Frame-end counter.
// ---------------------------------------------------------------------------
module detector_frame_sequencer #(
    parameter logic [7:0] CR_LOW_DEF  = 8'd140,
    parameter logic [7:0] CR_HIGH_DEF = 8'd255,
    parameter logic [7:0] CB_LOW_DEF  = 8'd0,
    parameter logic [7:0] CB_HIGH_DEF = 8'd120
) (
    input  logic       iVgaClk,
    input  logic       reset,
    input  logic       iVgaVRequest,
    input  logic       iCfgValid,
    output logic       oCfgReady,
    input  logic [1:0] iCfgSel,
    input  logic [7:0] iCfgData,
    input  logic       iSnapReq,
    input  logic       iSnapRelease,
    output logic [7:0] oCrLow,
    output logic [7:0] oCrHigh,
    output logic [7:0] oCbLow,
    output logic [7:0] oCbHigh,
    output logic       oFreezeRam,
    output logic [1:0] oSnapState,
    output logic       oCfgPending,
    output logic       oCfgErr
`ifdef FRAME_COUNTER_EN
    ,
    output logic [15:0] oFrameCount
`endif
);

    typedef enum logic [1:0] {
        LIVE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        FROZEN  = 2'd3
    } snapState_t;

    // A threshold pair is usable only if its low bound does not exceed its
    // high bound. The comparison is unsigned.
    function automatic logic pairOk(input logic [7:0] lo, input logic [7:0] hi);
        return (lo <= hi);
    endfunction

    // ---- stage p0: frame edge detection ------------------------------------
    logic vReqP1;
    logic edgeValid;
    logic frameStart;
    logic frameEnd;

    // vReqP1 also loads while reset is asserted. edgeValid suppresses any edge
    // in the first cycle after reset. Without it, a reset taken mid-frame
    // could produce a spurious frame_start or frame_end.
    always_ff @(posedge iVgaClk) begin
        vReqP1 <= iVgaVRequest;
        if (reset) begin
            edgeValid <= 1'b0;
        end else begin
            edgeValid <= 1'b1;
        end
    end

    assign frameStart = edgeValid &  iVgaVRequest & ~vReqP1;
    assign frameEnd   = edgeValid & ~iVgaVRequest &  vReqP1;

    // ---- stage p0: host handshake and commit decision ----------------------
    logic       cfgAccept;
    logic       commitNow;
    logic       crPairOk;
    logic       cbPairOk;
    logic [7:0] shCrLow;
    logic [7:0] shCrHigh;
    logic [7:0] shCbLow;
    logic [7:0] shCbHigh;

    // Writes are stalled during the commit cycle. A write that arrives then
    // therefore lands in the shadow for the following frame.
    assign oCfgReady = ~frameEnd;
    assign cfgAccept = iCfgValid & oCfgReady;
    assign commitNow = frameEnd & (oCfgPending | cfgAccept);
    assign crPairOk  = pairOk(shCrLow, shCrHigh);
    assign cbPairOk  = pairOk(shCbLow, shCbHigh);

    // ---- stage p1: shadow and active threshold registers -------------------
    always_ff @(posedge iVgaClk) begin
        if (reset) begin
            shCrLow     <= CR_LOW_DEF;
            shCrHigh    <= CR_HIGH_DEF;
            shCbLow     <= CB_LOW_DEF;
            shCbHigh    <= CB_HIGH_DEF;
            oCrLow      <= CR_LOW_DEF;
            oCrHigh     <= CR_HIGH_DEF;
            oCbLow      <= CB_LOW_DEF;
            oCbHigh     <= CB_HIGH_DEF;
            oCfgPending <= 1'b0;
            oCfgErr     <= 1'b0;
        end else begin
            oCfgErr <= 1'b0;
            if (commitNow) begin
                // Each pair is handled on its own. A rejected pair keeps its
                // old values, and its shadow is brought back to match them.
                if (crPairOk) begin
                    oCrLow  <= shCrLow;
                    oCrHigh <= shCrHigh;
                end else begin
                    shCrLow  <= oCrLow;
                    shCrHigh <= oCrHigh;
                end
                if (cbPairOk) begin
                    oCbLow  <= shCbLow;
                    oCbHigh <= shCbHigh;
                end else begin
                    shCbLow  <= oCbLow;
                    shCbHigh <= oCbHigh;
                end
                oCfgErr     <= ~(crPairOk & cbPairOk);
                oCfgPending <= 1'b0;
            end
            if (cfgAccept) begin
                case (iCfgSel)
                    2'd0:    shCrLow  <= iCfgData;
                    2'd1:    shCrHigh <= iCfgData;
                    2'd2:    shCbLow  <= iCfgData;
                    default: shCbHigh <= iCfgData;
                endcase
                oCfgPending <= 1'b1;
            end
        end
    end

    // ---- stage p1: snapshot sequencer --------------------------------------
    snapState_t snapState;

    // iSnapRelease has priority over iSnapReq in every state.
    // oFreezeRam is registered together with the state, so it follows the
    // state-changing event by one cycle.
    always_ff @(posedge iVgaClk) begin
        if (reset) begin
            snapState  <= LIVE;
            oFreezeRam <= 1'b0;
        end else begin
            case (snapState)
                LIVE: begin
                    if (iSnapReq && !iSnapRelease) begin
                        snapState <= ARM;
                    end
                end
                ARM: begin
                    // Entering ARM mid-frame does not count as a start.
                    // Only a real rising edge of iVgaVRequest moves on.
                    if (iSnapRelease) begin
                        snapState <= LIVE;
                    end else if (frameStart) begin
                        snapState <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (iSnapRelease) begin
                        snapState <= LIVE;
                    end else if (frameEnd) begin
                        snapState  <= FROZEN;
                        oFreezeRam <= 1'b1;
                    end
                end
                FROZEN: begin
                    if (iSnapRelease) begin
                        snapState  <= LIVE;
                        oFreezeRam <= 1'b0;
                    end else if (iSnapReq) begin
                        snapState  <= ARM;
                        oFreezeRam <= 1'b0;
                    end
                end
                default: begin
                    snapState  <= LIVE;
                    oFreezeRam <= 1'b0;
                end
            endcase
        end
    end

    assign oSnapState = snapState;

`ifdef FRAME_COUNTER_EN
    // ---- stage p1: frame counter -------------------------------------------
    logic [15:0] frameCount;

    // The counter is frozen along with the RAM. This lets software tag a
    // snapshot with the index of the frame it holds.
    always_ff @(posedge iVgaClk) begin
        if (reset) begin
            frameCount <= 16'd0;
        end else if (frameEnd && (snapState != FROZEN)) begin
            frameCount <= frameCount + 16'd1;
        end
    end

    assign oFrameCount = frameCount;
`endif

endmodule
